// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU clock-pulse controller: FSM state type and default parameters.
`default_nettype none

package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        S_STOP = 2'b00,
        S_RUN  = 2'b01,
        S_HALT = 2'b10
    } state_e;

    localparam int unsigned SYNC_STAGES_DEF     = 2;
    localparam logic [15:0] DEBOUNCE_CYCLES_DEF = 16'd50000;

endpackage

`default_nettype wire

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous level, plus a one-cycle rising-edge pulse.
`default_nettype none

module sync_edge_det
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic level_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/cpu_clk_pulse_ctrl.sv
// Turns the slow clock or a step button into single-cycle CPU enables with run/step/halt control.
// Optional step-button debounce when CPU_CLK_STEP_DEBOUNCE_EN is defined.
`default_nettype none

module cpu_clk_pulse_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter logic [15:0] DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             CLK,
    input  logic             CLRn,
    input  logic             clk_slow,
    input  logic             run_sw,
    input  logic             step_btn,
    input  logic             halt,
    output logic             cpu_en,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] step_cnt
);

    logic slow_lvl, tick;
    logic btn_lvl, btn_rise;
    logic run_s, run_rise;
    logic step_req;
    logic unused_w;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_slow (
        .clk_i(CLK), .rst_ni(CLRn), .d_i(clk_slow), .level_o(slow_lvl), .rise_o(tick)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_btn (
        .clk_i(CLK), .rst_ni(CLRn), .d_i(step_btn), .level_o(btn_lvl), .rise_o(btn_rise)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_run (
        .clk_i(CLK), .rst_ni(CLRn), .d_i(run_sw), .level_o(run_s), .rise_o(run_rise)
    );

`ifdef CPU_CLK_STEP_DEBOUNCE_EN
    logic        deb_q, deb_d;
    logic [15:0] deb_cnt_q, deb_cnt_d;

    // Request fires on the very sample that completes the stable run, so it lines up with the flip.
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        step_req  = 1'b0;
        if (btn_lvl != deb_q) begin
            if (deb_cnt_q + 16'd1 >= DEBOUNCE_CYCLES) begin
                deb_d    = btn_lvl;
                step_req = btn_lvl;
            end else begin
                deb_cnt_d = deb_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge CLRn) begin
        if (!CLRn) begin
            deb_q     <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    assign unused_w = ^{btn_rise, slow_lvl, run_rise};
`else
    assign step_req = btn_rise;
    assign unused_w = ^{DEBOUNCE_CYCLES, btn_lvl, slow_lvl, run_rise};
`endif

    state_e           state_q, state_d;
    logic             cpu_en_d, running_d, halted_d;
    logic [CNT_W-1:0] step_cnt_d;

    always_ff @(posedge CLK or negedge CLRn) begin
        if (!CLRn) begin
            state_q  <= S_STOP;
            cpu_en   <= 1'b0;
            running  <= 1'b0;
            halted   <= 1'b0;
            step_cnt <= '0;
        end else begin
            state_q  <= state_d;
            cpu_en   <= cpu_en_d;
            running  <= running_d;
            halted   <= halted_d;
            step_cnt <= step_cnt_d;
        end
    end

    // Halt outranks everything; a mode change outranks a pulse in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_STOP: begin
                if (halt)       state_d = S_HALT;
                else if (run_s) state_d = S_RUN;
            end
            S_RUN: begin
                if (halt)        state_d = S_HALT;
                else if (!run_s) state_d = S_STOP;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_STOP;
        endcase
    end

    always_comb begin
        cpu_en_d   = ((state_q == S_STOP) && !halt && !run_s && step_req) ||
                     ((state_q == S_RUN)  && !halt &&  run_s && tick);
        running_d  = (state_d == S_RUN);
        halted_d   = (state_d == S_HALT);
        step_cnt_d = step_cnt + {{(CNT_W-1){1'b0}}, cpu_en_d};
    end

endmodule

`default_nettype wire

// File: tb/tb_cpu_clk_pulse_ctrl.sv
// Randomized bench for cpu_clk_pulse_ctrl against a delay-queue reference model.
`default_nettype none

module tb_cpu_clk_pulse_ctrl;

    localparam int SYNC  = 2;
    localparam int CNT_W = 8;
    localparam int DEB   = 8;
`ifdef CPU_CLK_STEP_DEBOUNCE_EN
    localparam int EXP_P3 = 4;
`else
    localparam int EXP_P3 = 5;
`endif

    logic CLK = 1'b0;
    logic CLRn, clk_slow, run_sw, step_btn, halt;
    logic cpu_en, running, halted;
    logic [CNT_W-1:0] step_cnt;

    cpu_clk_pulse_ctrl #(
        .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(16'(DEB)), .CNT_W(CNT_W)
    ) dut (
        .CLK(CLK), .CLRn(CLRn), .clk_slow(clk_slow), .run_sw(run_sw),
        .step_btn(step_btn), .halt(halt), .cpu_en(cpu_en), .running(running),
        .halted(halted), .step_cnt(step_cnt)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_fail = 0;
    bit checking = 0;

    // Reference model: 0 = stopped, 1 = free-running, 2 = halted
    int m_state, m_cnt, m_dcnt;
    bit m_en, m_deb;
    bit cs_h[$], sb_h[$], rs_h[$];
    int slow_div = 0;
    int slow_ph  = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_en = 0; m_deb = 0; m_dcnt = 0;
        cs_h.delete(); sb_h.delete(); rs_h.delete();
        for (int i = 0; i <= SYNC; i++) begin
            cs_h.push_back(1'b0); sb_h.push_back(1'b0); rs_h.push_back(1'b0);
        end
    endtask

    // Index 0 of each history is the newest sample; index SYNC-1 is what the design sees now.
    task automatic model_edge();
        bit tick, req, run_s;
        if (!CLRn) return;
        tick  = cs_h[SYNC-1] && !cs_h[SYNC];
        run_s = rs_h[SYNC-1];
`ifdef CPU_CLK_STEP_DEBOUNCE_EN
        req = 1'b0;
        if (sb_h[SYNC-1] != m_deb) begin
            m_dcnt++;
            if (m_dcnt >= DEB) begin
                m_deb = sb_h[SYNC-1]; m_dcnt = 0; req = m_deb;
            end
        end else m_dcnt = 0;
`else
        req = sb_h[SYNC-1] && !sb_h[SYNC];
`endif
        m_en = 1'b0;
        if (m_state != 2 && halt) m_state = 2;
        else if (m_state == 0) begin
            if (run_s) m_state = 1;
            else if (req) m_en = 1'b1;
        end else if (m_state == 1) begin
            if (!run_s) m_state = 0;
            else if (tick) m_en = 1'b1;
        end
        if (m_en) m_cnt = (m_cnt + 1) % (1 << CNT_W);
        cs_h.push_front(clk_slow); void'(cs_h.pop_back());
        sb_h.push_front(step_btn); void'(sb_h.pop_back());
        rs_h.push_front(run_sw);   void'(rs_h.pop_back());
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic cyc();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            if (slow_div > 0) begin
                slow_ph++;
                if (slow_ph >= slow_div) begin slow_ph = 0; clk_slow = ~clk_slow; end
            end
            cyc();
        end
    endtask

    // Reset asserted between edges so that a pulse in flight is dropped asynchronously.
    task automatic mid_reset();
        #2;
        CLRn = 1'b0;
        model_reset();
        #1;
        check("async_drop_cpu_en", cpu_en, 0);
        @(negedge CLK);
        cyc();
        cyc();
        CLRn = 1'b1;
    endtask

    always @(negedge CLK) begin
        if (checking) begin
            check("cpu_en", cpu_en, m_en);
            check("running", running, m_state == 1);
            check("halted", halted, m_state == 2);
            check("step_cnt", step_cnt, m_cnt);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, seen;
        CLRn = 1'b0; clk_slow = 0; run_sw = 0; step_btn = 0; halt = 0;
        model_reset();
        @(negedge CLK);
        checking = 1;

        // Reset held with inputs toggling
        for (int i = 0; i < 3; i++) begin
            clk_slow = 1'($urandom); run_sw = 1'($urandom);
            step_btn = 1'($urandom); halt = 1'($urandom);
            cyc();
        end
        check("reset_step_cnt", step_cnt, 0);
        check("reset_running", running, 0);
        clk_slow = 0; run_sw = 0; step_btn = 0; halt = 0;
        CLRn = 1'b1;

        // Free run, 20-cycle slow clock
        run_sw = 1;
        run_cycles(4);
        check("run_entered", running, 1);
        clk_slow = 1;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            if (cpu_en && lat == 0) lat = i;
        end
        check("tick_latency", lat, SYNC + 1);
        clk_slow = 0;
        run_cycles(10);
        slow_div = 10; slow_ph = 0;
        run_cycles(40);
        check("run_three_ticks", step_cnt, 3);

        // Single step with the slow clock still toggling
        run_sw = 0;
        run_cycles(6);
        step_btn = 1; run_cycles(5);
        step_btn = 0; run_cycles(20);
        step_btn = 1; run_cycles(100);
        step_btn = 0; run_cycles(20);
        check("step_two_presses", step_cnt, EXP_P3);

        // Halt coincident with a tick
        slow_div = 0; clk_slow = 0;
        run_sw = 1;
        run_cycles(8);
        clk_slow = 1;
        for (int i = 0; i < SYNC; i++) cyc();
        halt = 1;
        cyc();
        check("halt_blocks_tick", cpu_en, 0);
        check("halt_halted", halted, 1);
        check("halt_running", running, 0);
        halt = 0;
        slow_div = 5; slow_ph = 0;
        for (int i = 0; i < 6; i++) begin
            step_btn = ~step_btn; run_sw = 1'($urandom);
            run_cycles(10);
        end
        check("halt_sticky", halted, 1);
        check("halt_cnt_frozen", step_cnt, EXP_P3);
        mid_reset();
        check("after_reset_halted", halted, 0);
        check("after_reset_cnt", step_cnt, 0);

        // Counter wrap over 256 pulses
        step_btn = 0; run_sw = 1; slow_div = 2; slow_ph = 0; clk_slow = 0;
        seen = 0;
        for (int i = 0; i < 2000 && seen < 256; i++) begin
            run_cycles(1);
            if (cpu_en) begin
                seen++;
                if (seen == 255) check("cnt_255", step_cnt, 255);
                if (seen == 256) check("cnt_wrap", step_cnt, 0);
            end
        end
        check("wrap_pulses_seen", seen, 256);

        // Random traffic
        slow_div = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) == 0) run_sw = ~run_sw;
            if ($urandom_range(0, 5) == 0) clk_slow = ~clk_slow;
`ifdef CPU_CLK_STEP_DEBOUNCE_EN
            if ($urandom_range(0, 14) == 0) step_btn = ~step_btn;
`else
            if ($urandom_range(0, 7) == 0) step_btn = ~step_btn;
`endif
            halt = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 499) == 0) mid_reset();
            else cyc();
        end

        checking = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
